// File: rtl/rv_mem_adapter.sv
// Bridges a valid/ready core memory port to a 64-bit synchronous on-chip RAM, one transaction per 3 cycles.
// Optional address checking is enabled by defining RV_MEM_ADAPTER_ERRCHK_EN.
module rv_mem_adapter #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 8192
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [3:0]  req_wstrb,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [12:0] mem_address,
  output logic [7:0]  mem_byteenable,
  output logic        mem_chipselect,
  output logic        mem_write,
  output logic [63:0] mem_writedata,
  output logic        mem_clken,
  input  logic [63:0] mem_readdata
);

  localparam logic [31:0] WORD_MASK = 32'(MEM_WORDS - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e      state_q, state_d;
  logic        ready_q, ready_d;
  logic        cs_q, cs_d;
  logic        wr_q, wr_d;
  logic [12:0] addr_q, addr_d;
  logic [7:0]  be_q, be_d;
  logic [63:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        hi_q, hi_d;
  logic        err_q, err_d;
  logic        rvalid_q, rvalid_d;
  logic        rerr_q, rerr_d;
  logic        clken_q;
  logic        addr_err;

`ifdef RV_MEM_ADAPTER_ERRCHK_EN
  localparam logic [32:0] END_ADDR = 33'(BASE_ADDR) + 33'(MEM_WORDS) * 33'd8;

  // Misaligned, below the window, or past the end of the memory
  assign addr_err = (req_addr[1:0] != 2'b00) || (req_addr < BASE_ADDR) ||
                    ({1'b0, req_addr} >= END_ADDR);
`else
  assign addr_err = 1'b0;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    cs_d     = 1'b0;
    wr_d     = 1'b0;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    hi_d     = hi_q;
    err_d    = err_q;
    rvalid_d = 1'b0;
    rerr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && ready_q) begin
          state_d = ACCESS;
          addr_d  = 13'(((req_addr - BASE_ADDR) >> 3) & WORD_MASK);
          wdata_d = {req_wdata, req_wdata};
          we_d    = req_we;
          hi_d    = req_addr[2];
          err_d   = addr_err;
          cs_d    = !addr_err;
          wr_d    = req_we && !addr_err;
          if (req_we) begin
            be_d = req_addr[2] ? {req_wstrb, 4'b0000} : {4'b0000, req_wstrb};
          end else begin
            be_d = 8'hFF;
          end
        end
      end
      ACCESS: begin
        state_d  = RESP;
        rvalid_d = 1'b1;
        rerr_d   = err_q;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      ready_q  <= 1'b0;
      cs_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= 13'd0;
      be_q     <= 8'd0;
      wdata_q  <= 64'd0;
      we_q     <= 1'b0;
      hi_q     <= 1'b0;
      err_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
      clken_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      cs_q     <= cs_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      hi_q     <= hi_d;
      err_q    <= err_d;
      rvalid_q <= rvalid_d;
      rerr_q   <= rerr_d;
      clken_q  <= 1'b1;
    end
  end

  assign req_ready      = ready_q;
  assign resp_valid     = rvalid_q;
  assign resp_err       = rerr_q;
  assign mem_address    = addr_q;
  assign mem_byteenable = be_q;
  assign mem_chipselect = cs_q;
  assign mem_write      = wr_q;
  assign mem_writedata  = wdata_q;
  assign mem_clken      = clken_q;

  // RAM data only becomes valid in RESP, so read data is steered straight through
  assign resp_rdata = (rvalid_q && !we_q && !err_q) ?
                      (hi_q ? mem_readdata[63:32] : mem_readdata[31:0]) : 32'h0;

endmodule

// File: tb/tb_rv_mem_adapter.sv
// Self-checking bench for rv_mem_adapter: behavioural RAM, reference word model and response scoreboard.
module tb_rv_mem_adapter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [3:0]  req_wstrb;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [12:0] mem_address;
  logic [7:0]  mem_byteenable;
  logic        mem_chipselect;
  logic        mem_write;
  logic [63:0] mem_writedata;
  logic        mem_clken;
  logic [63:0] mem_readdata;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad_cnt = 0;
  int          cyc = 0;
  logic [31:0] last_rdata = 32'h0;
  logic [63:0] ram [0:8191];
  logic [63:0] rd_q = 64'h0;
  logic [31:0] ref_mem [0:16383];

  rv_mem_adapter #(.BASE_ADDR(32'h0000_0000), .MEM_WORDS(8192)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM: address registered by the adapter, sampled here, data out one cycle later
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write)
        for (int b = 0; b < 8; b++)
          if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
      rd_q <= ram[mem_address];
    end
  end
  assign mem_readdata = rd_q;

  // Response monitor: in-order compare against the scoreboard
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      exp_t e;
      if (sb.size() == 0) begin
        total++; bad_cnt++;
        $display("FAIL unexpected_resp cyc=%0d rdata=%h err=%b", cyc, resp_rdata, resp_err);
      end else begin
        e = sb.pop_front();
        last_rdata = resp_rdata;
        total++;
        if (resp_rdata !== e.rdata) begin
          bad_cnt++; $display("FAIL resp_rdata got=%h exp=%h", resp_rdata, e.rdata);
        end
        total++;
        if (resp_err !== e.err) begin
          bad_cnt++; $display("FAIL resp_err got=%b exp=%b", resp_err, e.err);
        end
        total++;
        if (cyc !== e.cyc) begin
          bad_cnt++; $display("FAIL resp_cycle got=%0d exp=%0d", cyc, e.cyc);
        end
      end
    end
  end

  function automatic logic addr_bad(input logic [31:0] a);
`ifdef RV_MEM_ADAPTER_ERRCHK_EN
    return (a[1:0] != 2'b00) || (a >= 32'h0001_0000);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & 32'h3FFF);
  endfunction

  // Issue one request; caller is at a negedge. Returns at the ACCESS-cycle negedge with req_valid still high.
  task automatic do_req(input logic [31:0] a, input logic we, input logic [3:0] s,
                        input logic [31:0] d, output int hc);
    int   n;
    exp_t e;
    logic bad;
    int   i;
    n = 0;
    req_valid = 1'b1; req_addr = a; req_we = we; req_wstrb = s; req_wdata = d;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk); n++;
    end
    if (req_ready !== 1'b1) begin
      total++; bad_cnt++;
      $display("FAIL handshake_timeout addr=%h ready=%b", a, req_ready);
      hc = -1;
      return;
    end
    hc  = cyc;
    bad = addr_bad(a);
    i   = widx(a);
    e.err = bad;
    e.cyc = cyc + 2;
    e.rdata = (bad || we) ? 32'h0 : ref_mem[i];
    if (we && !bad)
      for (int b = 0; b < 4; b++)
        if (s[b]) ref_mem[i][b*8 +: 8] = d[b*8 +: 8];
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic drain;
    int n;
    n = 0;
    while (sb.size() != 0 && n < 12) begin
      @(negedge clk); #1; n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad_cnt++; $display("FAIL drain_timeout pending=%0d exp=0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset_n = 1'b0; req_valid = 1'b0; req_addr = 32'h0; req_we = 1'b0;
    req_wstrb = 4'h0; req_wdata = 32'h0;
    @(negedge clk); @(negedge clk);
    total++;
    if ({req_ready, resp_valid, resp_err, mem_chipselect, mem_write, mem_clken} !== 6'b0) begin
      bad_cnt++; $display("FAIL reset_ctrl got=%b exp=000000",
        {req_ready, resp_valid, resp_err, mem_chipselect, mem_write, mem_clken});
    end
    total++;
    if ({resp_rdata, mem_address, mem_byteenable, mem_writedata} !== 117'd0) begin
      bad_cnt++; $display("FAIL reset_data got=%h/%h/%h/%h exp=0",
        resp_rdata, mem_address, mem_byteenable, mem_writedata);
    end
    reset_n = 1'b1;
    #1;
    total++;
    if (req_ready !== 1'b0) begin
      bad_cnt++; $display("FAIL ready_at_release got=%b exp=0", req_ready);
    end
    @(negedge clk);
    total++;
    if ({req_ready, mem_clken} !== 2'b11) begin
      bad_cnt++; $display("FAIL ready_clken_after_release got=%b exp=11", {req_ready, mem_clken});
    end
  endtask

  task automatic test_write_read;
    int hc;
    do_req(32'h0000_0004, 1'b1, 4'hF, 32'hDEADBEEF, hc);
    req_valid = 1'b0;
    total++;
    if ({mem_chipselect, mem_write, mem_byteenable, mem_address} !== {2'b11, 8'hF0, 13'd0}) begin
      bad_cnt++; $display("FAIL wr_mem_ctrl got cs=%b we=%b be=%h a=%h exp cs=1 we=1 be=f0 a=0",
        mem_chipselect, mem_write, mem_byteenable, mem_address);
    end
    total++;
    if (mem_writedata !== 64'hDEADBEEF_DEADBEEF) begin
      bad_cnt++; $display("FAIL wr_mem_data got=%h exp=deadbeefdeadbeef", mem_writedata);
    end
    drain();
    do_req(32'h0000_0004, 1'b0, 4'h0, 32'h0, hc);
    req_valid = 1'b0;
    total++;
    if ({mem_chipselect, mem_write, mem_byteenable, resp_rdata} !== {2'b10, 8'hFF, 32'h0}) begin
      bad_cnt++; $display("FAIL rd_mem_ctrl got cs=%b we=%b be=%h rdata=%h exp cs=1 we=0 be=ff rdata=0",
        mem_chipselect, mem_write, mem_byteenable, resp_rdata);
    end
    drain();
    total++;
    if (last_rdata !== 32'hDEADBEEF) begin
      bad_cnt++; $display("FAIL write_read got=%h exp=deadbeef", last_rdata);
    end
  endtask

  task automatic test_partial_write;
    int hc;
    do_req(32'h0000_0010, 1'b1, 4'hF, 32'h11223344, hc);
    req_valid = 1'b0; drain();
    do_req(32'h0000_0010, 1'b1, 4'b0010, 32'h0000AB00, hc);
    req_valid = 1'b0;
    total++;
    if (mem_byteenable !== 8'h02) begin
      bad_cnt++; $display("FAIL partial_be got=%h exp=02", mem_byteenable);
    end
    drain();
    do_req(32'h0000_0010, 1'b0, 4'h0, 32'h0, hc);
    req_valid = 1'b0; drain();
    total++;
    if (last_rdata !== 32'h1122AB44) begin
      bad_cnt++; $display("FAIL partial_write got=%h exp=1122ab44", last_rdata);
    end
  endtask

  task automatic test_back_to_back;
    int h0, h1, h2;
    do_req(32'h0000_0020, 1'b1, 4'hF, 32'hCAFEF00D, h0);
    total++;
    if (req_ready !== 1'b0) begin
      bad_cnt++; $display("FAIL b2b_ready_access got=%b exp=0", req_ready);
    end
    @(negedge clk);
    total++;
    if (req_ready !== 1'b0) begin
      bad_cnt++; $display("FAIL b2b_ready_resp got=%b exp=0", req_ready);
    end
    do_req(32'h0000_0024, 1'b1, 4'hF, 32'h0BADC0DE, h1);
    do_req(32'h0000_0020, 1'b0, 4'h0, 32'h0, h2);
    req_valid = 1'b0;
    total++;
    if ((h1 - h0) != 3 || (h2 - h0) != 6) begin
      bad_cnt++; $display("FAIL b2b_spacing got=%0d,%0d exp=3,6", h1 - h0, h2 - h0);
    end
    drain();
    do_req(32'h0000_0024, 1'b0, 4'h0, 32'h0, h0);
    req_valid = 1'b0; drain();
  endtask

  task automatic test_addr_check;
    int hc;
    do_req(32'h0000_0000, 1'b1, 4'hF, 32'h55AA1234, hc);
    req_valid = 1'b0; drain();
    do_req(32'h0001_0000, 1'b0, 4'h0, 32'h0, hc);
    req_valid = 1'b0;
`ifdef RV_MEM_ADAPTER_ERRCHK_EN
    total++;
    if (mem_chipselect !== 1'b0) begin
      bad_cnt++; $display("FAIL err_range_cs got=%b exp=0", mem_chipselect);
    end
`endif
    drain();
    do_req(32'h0000_0002, 1'b0, 4'h0, 32'h0, hc);
    req_valid = 1'b0;
`ifdef RV_MEM_ADAPTER_ERRCHK_EN
    total++;
    if (mem_chipselect !== 1'b0) begin
      bad_cnt++; $display("FAIL err_align_cs got=%b exp=0", mem_chipselect);
    end
`else
    total++;
    if (mem_address !== 13'd0) begin
      bad_cnt++; $display("FAIL unaligned_addr got=%h exp=0", mem_address);
    end
`endif
    drain();
  endtask

  task automatic test_reset_mid;
    int          hc;
    exp_t        dropped;
    logic [31:0] save;
    logic        seen;
    save = ref_mem[widx(32'h40)];
    do_req(32'h0000_0040, 1'b1, 4'hF, 32'h99999999, hc);
    req_valid = 1'b0;
    total++;
    if (mem_chipselect !== 1'b1) begin
      bad_cnt++; $display("FAIL mid_cs_before got=%b exp=1", mem_chipselect);
    end
    reset_n = 1'b0;
    #1;
    total++;
    if ({mem_chipselect, mem_write, req_ready, mem_clken} !== 4'b0000) begin
      bad_cnt++; $display("FAIL mid_reset_ctrl got=%b exp=0000",
        {mem_chipselect, mem_write, req_ready, mem_clken});
    end
    dropped = sb.pop_back();
    ref_mem[widx(32'h40)] = save;
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    #1;
    total++;
    if (req_ready !== 1'b0) begin
      bad_cnt++; $display("FAIL mid_ready_release got=%b exp=0", req_ready);
    end
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1) begin
      bad_cnt++; $display("FAIL mid_ready_one_clock got=%b exp=1", req_ready);
    end
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1 if (resp_valid !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    total++;
    if (seen) begin
      bad_cnt++; $display("FAIL mid_no_resp got=1 exp=0");
    end
    do_req(32'h0000_0040, 1'b0, 4'h0, 32'h0, hc);
    req_valid = 1'b0; drain();
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) ram[i] = 64'h0;
    for (int i = 0; i < 16384; i++) ref_mem[i] = 32'h0;
    test_reset();
    test_write_read();
    test_partial_write();
    test_back_to_back();
    test_addr_check();
    test_reset_mid();
    total++;
    if (sb.size() != 0) begin
      bad_cnt++; $display("FAIL scoreboard_left got=%0d exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout total=%0d bad=%0d", total, bad_cnt);
    $fatal(1, "timeout");
  end

endmodule
